ecmac_pe_param: RTL

- Parametrised error-compensation MAC processing element for low-voltage systolic DNN arrays. Next generation of the single-slot 8-bit error-compensation MAC.
- Computes psum_out = psum + weight*activation. Substitutes a shadow-sampled partial sum when a timing error is flagged, and forwards the uncommitted product downstream for later compensation.
- Adds three things the previous MAC lacked:
  - stationary weight register;
  - a small FIFO that buffers colliding error products, which were previously dropped;
  - saturating error counter and sticky overflow status.

---
 rtl/ecmac_pe_param.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ecmac_pe_param.sv
// Error-compensating MAC processing element for a systolic array.
// It holds a stationary weight, buffers colliding error products in a small FIFO and counts local timing errors.
module ecmac_pe_param #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int SIGNED = 0,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  weight_load,
  input  logic [DATA_W-1:0]     weight_in,
  input  logic [DATA_W-1:0]     act_in,
  input  logic                  act_valid_in,
  input  logic [ACC_W-1:0]      psum_in,
  input  logic [ACC_W-1:0]      psum_shadow_in,
  input  logic                  psum_err_in,
  input  logic [2*DATA_W-1:0]   err_prod_in,
  input  logic                  err_valid_in,
  output logic [DATA_W-1:0]     act_out,
  output logic                  act_valid_out,
  output logic [ACC_W-1:0]      psum_out,
  output logic [2*DATA_W-1:0]   err_prod_out,
  output logic                  err_valid_out,
  output logic [CNT_W-1:0]      err_count,
  output logic                  fifo_overflow
);
  localparam int PW = 2 * DATA_W;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] weight_q, act_q;
  logic              v_q, perr_q, evalid_q;
  logic [ACC_W-1:0]  psum_q, shadow_q;
  logic [PW-1:0]     eprod_q;

  logic [PW-1:0]     fifo_mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       fill_q, fill_d;
  logic [CNT_W-1:0]  err_count_q;
  logic              ovf_q;

  logic [PW-1:0]     prod;
  logic [ACC_W-1:0]  prod_ext, sum;
  logic              le, ie, fifo_empty, fifo_full, push, pop;

  // Operands are widened to the product width first so the multiply keeps every bit.
  generate
    if (SIGNED != 0) begin : g_signed
      logic signed [PW-1:0] w_s, a_s;
      assign w_s      = PW'($signed(weight_q));
      assign a_s      = PW'($signed(act_q));
      assign prod     = w_s * a_s;
      assign prod_ext = ACC_W'($signed(prod));
    end else begin : g_unsigned
      assign prod     = PW'(weight_q) * PW'(act_q);
      assign prod_ext = ACC_W'(prod);
    end
  endgenerate

  assign sum        = psum_q + prod_ext;
  assign le         = v_q & perr_q;
  assign ie         = evalid_q;
  assign fifo_empty = (fill_q == '0);
  assign fifo_full  = (fill_q == (AW+1)'(DEPTH));
  // A push needs le, a pop needs !le, so they can never coincide.
  assign push       = le & ie;
  assign pop        = ~le & ~ie & ~fifo_empty;

  always_comb begin
    fill_d = fill_q;
    if (push && !fifo_full) fill_d = fill_q + 1'b1;
    else if (pop)           fill_d = fill_q - 1'b1;
  end

  always_comb begin
    act_out       = act_q;
    act_valid_out = v_q;
    err_count     = err_count_q;
    fifo_overflow = ovf_q;
    if (le)       psum_out = shadow_q;
    else if (v_q) psum_out = sum;
    else          psum_out = psum_q;
    err_prod_out  = '0;
    err_valid_out = 1'b0;
    if (le) begin
      err_prod_out  = prod;
      err_valid_out = 1'b1;
    end else if (ie) begin
      err_prod_out  = eprod_q;
      err_valid_out = 1'b1;
    end else if (!fifo_empty) begin
      err_prod_out  = fifo_mem[rd_ptr_q];
      err_valid_out = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !fifo_full) fifo_mem[wr_ptr_q] <= eprod_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      weight_q    <= '0;
      act_q       <= '0;
      v_q         <= 1'b0;
      psum_q      <= '0;
      shadow_q    <= '0;
      perr_q      <= 1'b0;
      eprod_q     <= '0;
      evalid_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      err_count_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      if (weight_load) weight_q <= weight_in;
      act_q    <= act_in;
      v_q      <= act_valid_in;
      psum_q   <= psum_in;
      shadow_q <= psum_shadow_in;
      perr_q   <= psum_err_in;
      eprod_q  <= err_prod_in;
      evalid_q <= err_valid_in;
      fill_q   <= fill_d;
      if (push && !fifo_full) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (push && fifo_full)  ovf_q    <= 1'b1;
      if (pop)                rd_ptr_q <= rd_ptr_q + 1'b1;
      if (le && err_count_q != {CNT_W{1'b1}}) err_count_q <= err_count_q + 1'b1;
    end
  end
endmodule
